// File: rtl/approx_adder_pkg.sv
// Shared constants and helpers for the pipelined approximate adder.
// Default geometry: 12-bit operands, 4 approximated low bits, two 4-bit lookahead segments.
package approx_adder_pkg;

    localparam int DEF_WIDTH       = 12;
    localparam int DEF_LCA_WIDTH   = 4;
    localparam int DEF_APPROX_BITS = 4;
    localparam int ERR_CNT_W       = 16;

    // Number of lookahead segments, which is also the pipeline depth.
    function automatic int calc_n_seg(input int width, input int approx_bits, input int lca_width);
        return (width - approx_bits) / lca_width;
    endfunction

endpackage

// File: rtl/pipe_approx_adder_if.sv
// Operand/result handshake bundle for pipe_approx_adder.
// The slave modport is the adder's view; master is the producer/consumer side.
interface pipe_approx_adder_if
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic                 approx_en;
    logic                 cin;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     s;
    logic                 cout;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, approx_en, cin, a, b, out_ready,
        output in_ready, out_valid, s, cout, err_count
    );

    modport master (
        output in_valid, approx_en, cin, a, b, out_ready,
        input  in_ready, out_valid, s, cout, err_count
    );

endinterface

// File: rtl/lca_nbit.sv
// Combinational lookahead-carry adder segment; every carry is a flat
// sum-of-products of generate/propagate terms rather than a ripple chain.
module lca_nbit #(
    parameter int LCA_WIDTH = 4
) (
    input  logic                 cin,
    input  logic [LCA_WIDTH-1:0] a,
    input  logic [LCA_WIDTH-1:0] b,
    output logic [LCA_WIDTH-1:0] s,
    output logic                 cout
);

    logic [LCA_WIDTH-1:0] g;
    logic [LCA_WIDTH-1:0] p;
    logic [LCA_WIDTH:0]   c;
    logic                 prod;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        prod = 1'b0;
        for (int i = 0; i < LCA_WIDTH; i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & cin);
        end
        s    = p ^ c[LCA_WIDTH-1:0];
        cout = c[LCA_WIDTH];
    end

endmodule

// File: rtl/pipe_approx_adder.sv
// Pipelined approximate adder: one lookahead segment per stage, valid/ready with backpressure.
// Optional error statistics enabled by defining PIPE_APPROX_ADDER_ERR_STATS_EN.
module pipe_approx_adder
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LCA_WIDTH   = DEF_LCA_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS
) (
    input logic                clk,
    input logic                rst_n,
    pipe_approx_adder_if.slave bus
);

    localparam int N_SEG  = calc_n_seg(WIDTH, APPROX_BITS, LCA_WIDTH);
    localparam int LO_MSB = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
    localparam logic [WIDTH:0] LO_MASK = ((WIDTH+1)'(1) << APPROX_BITS) - (WIDTH+1)'(1);

    if (APPROX_BITS < 0 || APPROX_BITS > WIDTH - LCA_WIDTH ||
        ((WIDTH - APPROX_BITS) % LCA_WIDTH) != 0) begin : g_bad_cfg
        $fatal(1, "pipe_approx_adder: illegal WIDTH/LCA_WIDTH/APPROX_BITS combination");
    end

    logic [N_SEG-1:0] vld_q, vld_d, mode_q, mode_d, cy_q, cy_d, en;
    logic [WIDTH-1:0] sum_q [N_SEG];
    logic [WIDTH-1:0] sum_d [N_SEG];
    logic [WIDTH-1:0] a_q   [N_SEG];
    logic [WIDTH-1:0] a_d   [N_SEG];
    logic [WIDTH-1:0] b_q   [N_SEG];
    logic [WIDTH-1:0] b_d   [N_SEG];
    logic             rdy_q, rdy_d;
    logic             go;
    logic             in_ready;

    logic [WIDTH:0]       lo_ex;
    logic [WIDTH-1:0]     lo_s;
    logic                 lo_c;
    logic [LCA_WIDTH-1:0] seg_a  [N_SEG];
    logic [LCA_WIDTH-1:0] seg_b  [N_SEG];
    logic [LCA_WIDTH-1:0] seg_s  [N_SEG];
    logic                 seg_ci [N_SEG];
    logic                 seg_co [N_SEG];
    logic                 unused_bits;

    // Approximate mode replicates a's top low bit and reuses it as the segment-0 carry.
    always_comb begin
        lo_ex = ({1'b0, bus.a} & LO_MASK) + ({1'b0, bus.b} & LO_MASK) + (WIDTH+1)'(bus.cin);
        if (bus.approx_en) begin
            lo_s = {WIDTH{bus.a[LO_MSB]}} & LO_MASK[WIDTH-1:0];
            lo_c = (APPROX_BITS == 0) ? bus.cin : bus.a[LO_MSB];
        end else begin
            lo_s = lo_ex[WIDTH-1:0] & LO_MASK[WIDTH-1:0];
            lo_c = lo_ex[APPROX_BITS];
        end
    end

    for (genvar k = 0; k < N_SEG; k++) begin : g_seg
        localparam int LSB = APPROX_BITS + k * LCA_WIDTH;
        if (k == 0) begin : g_first
            assign seg_a[k]  = bus.a[LSB +: LCA_WIDTH];
            assign seg_b[k]  = bus.b[LSB +: LCA_WIDTH];
            assign seg_ci[k] = lo_c;
        end else begin : g_next
            assign seg_a[k]  = a_q[k-1][LSB +: LCA_WIDTH];
            assign seg_b[k]  = b_q[k-1][LSB +: LCA_WIDTH];
            assign seg_ci[k] = cy_q[k-1];
        end
        lca_nbit #(.LCA_WIDTH(LCA_WIDTH)) u_lca (
            .cin  (seg_ci[k]),
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .s    (seg_s[k]),
            .cout (seg_co[k])
        );
    end

    // A stage may load when it is empty or everything downstream of it is moving.
    always_comb begin
        rdy_d = 1'b1;
        en    = '0;
        go    = bus.out_ready;
        for (int k = N_SEG - 1; k >= 0; k--) begin
            go    = go | ~vld_q[k];
            en[k] = go;
        end
        in_ready = rdy_q & en[0];

        vld_d  = vld_q;
        mode_d = mode_q;
        cy_d   = cy_q;
        for (int k = 0; k < N_SEG; k++) begin
            sum_d[k] = sum_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
        end

        if (en[0]) begin
            vld_d[0]  = bus.in_valid & in_ready;
            mode_d[0] = bus.approx_en;
            cy_d[0]   = seg_co[0];
            a_d[0]    = bus.a;
            b_d[0]    = bus.b;
            sum_d[0]  = lo_s;
            sum_d[0][APPROX_BITS +: LCA_WIDTH] = seg_s[0];
        end
        for (int k = 1; k < N_SEG; k++) begin
            if (en[k]) begin
                vld_d[k]  = vld_q[k-1];
                mode_d[k] = mode_q[k-1];
                cy_d[k]   = seg_co[k];
                a_d[k]    = a_q[k-1];
                b_d[k]    = b_q[k-1];
                sum_d[k]  = sum_q[k-1];
                sum_d[k][APPROX_BITS + k*LCA_WIDTH +: LCA_WIDTH] = seg_s[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            vld_q  <= '0;
            mode_q <= '0;
            cy_q   <= '0;
            for (int k = 0; k < N_SEG; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            rdy_q  <= rdy_d;
            vld_q  <= vld_d;
            mode_q <= mode_d;
            cy_q   <= cy_d;
            for (int k = 0; k < N_SEG; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_q[N_SEG-1];
    assign bus.s         = sum_q[N_SEG-1];
    assign bus.cout      = cy_q[N_SEG-1];

`ifdef PIPE_APPROX_ADDER_ERR_STATS_EN
    logic [WIDTH:0]       ex_q [N_SEG];
    logic [WIDTH:0]       ex_d [N_SEG];
    logic [ERR_CNT_W-1:0] err_q, err_d;

    always_comb begin
        for (int k = 0; k < N_SEG; k++) ex_d[k] = ex_q[k];
        if (en[0]) ex_d[0] = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
        for (int k = 1; k < N_SEG; k++) begin
            if (en[k]) ex_d[k] = ex_q[k-1];
        end
        err_d = err_q;
        if (vld_q[N_SEG-1] && bus.out_ready && mode_q[N_SEG-1] &&
            ({cy_q[N_SEG-1], sum_q[N_SEG-1]} != ex_q[N_SEG-1]) && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            for (int k = 0; k < N_SEG; k++) ex_q[k] <= '0;
        end else begin
            err_q <= err_d;
            for (int k = 0; k < N_SEG; k++) ex_q[k] <= ex_d[k];
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

    // Operand bits already consumed by earlier stages are intentionally left dangling.
    always_comb begin
        unused_bits = ^{lo_ex, mode_q};
        for (int k = 0; k < N_SEG; k++) unused_bits = unused_bits ^ (^a_q[k]) ^ (^b_q[k]);
    end

endmodule

// File: tb/tb_pipe_approx_adder.sv
// Scoreboard bench for pipe_approx_adder: default 12-bit approximate build plus a
// 16-bit exact-only build (APPROX_BITS=0) for a random sweep.
module tb_pipe_approx_adder;
    import approx_adder_pkg::*;

    localparam int LAT12 = 2;
    localparam int LAT16 = 4;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        diff;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_approx_adder_if #(.WIDTH(12)) bus ();
    pipe_approx_adder_if #(.WIDTH(16)) bus16 ();

    pipe_approx_adder #(.WIDTH(12), .LCA_WIDTH(4), .APPROX_BITS(4)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    pipe_approx_adder #(.WIDTH(16), .LCA_WIDTH(4), .APPROX_BITS(0)) dut16 (
        .clk (clk), .rst_n (rst_n), .bus (bus16)
    );

    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   exp_err = 0;
    exp_t sb [$];

    logic [11:0] op_a  [$];
    logic [11:0] op_b  [$];
    logic        op_c  [$];
    logic        op_ap [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model12(input logic [11:0] a, input logic [11:0] b,
                                     input logic ci, input logic ap, input int c);
        exp_t        m;
        logic [12:0] ex;
        logic [12:0] r;
        ex = {1'b0, a} + {1'b0, b} + {12'd0, ci};
        if (ap) r = {({1'b0, a[11:4]} + {1'b0, b[11:4]} + {8'd0, a[3]}), {4{a[3]}}};
        else    r = ex;
        m.s    = {4'd0, r[11:0]};
        m.cout = r[12];
        m.diff = ap && (r != ex);
        m.cyc  = c;
        return m;
    endfunction

    task automatic load_ops();
        op_a.delete(); op_b.delete(); op_c.delete(); op_ap.delete();
    endtask

    task automatic add_op(input logic [11:0] a, input logic [11:0] b, input logic ci, input logic ap);
        op_a.push_back(a); op_b.push_back(b); op_c.push_back(ci); op_ap.push_back(ap);
    endtask

    task automatic drive_op(input int i);
        bus.in_valid  = 1'b1;
        bus.a         = op_a[i];
        bus.b         = op_b[i];
        bus.cin       = op_c[i];
        bus.approx_en = op_ap[i];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.approx_en = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.approx_en = 1'b0;
        #3;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b expected 0", bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); else passed++;
        checks++; if ({bus.cout, bus.s} !== 13'd0) $display("FAIL reset_sum got %h expected 0", {bus.cout, bus.s}); else passed++;
        checks++; if (bus.err_count !== 16'd0) $display("FAIL reset_err_count got %0d expected 0", bus.err_count); else passed++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %b expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_approx_modes();
        int   sent = 0, got = 0, guard = 0, n;
        exp_t e;
        load_ops();
        add_op(12'h0A5, 12'h013, 1'b0, 1'b1);
        add_op(12'h0A5, 12'h013, 1'b1, 1'b1);
        add_op(12'h0F8, 12'h001, 1'b0, 1'b1);
        add_op(12'h0F8, 12'h001, 1'b0, 1'b0);
        add_op(12'hFFF, 12'h001, 1'b0, 1'b0);
        add_op(12'hFFF, 12'h0F0, 1'b0, 1'b1);
        add_op(12'h123, 12'h456, 1'b1, 1'b0);
        n = op_a.size();
        bus.out_ready = 1'b1;
        while (got < n && guard < 200) begin
            @(posedge clk); #1; guard++;
            if (sent < n) drive_op(sent); else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model12(bus.a, bus.b, bus.cin, bus.approx_en, cyc)); sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) $display("FAIL modes_spurious_output got valid expected none");
                else begin
                    e = sb.pop_front();
                    if ({bus.cout, bus.s} !== {e.cout, e.s[11:0]})
                        $display("FAIL modes_sum op%0d got %h expected %h", got, {bus.cout, bus.s}, {e.cout, e.s[11:0]});
                    else passed++;
                    checks++;
                    if (cyc - e.cyc != LAT12) $display("FAIL modes_latency op%0d got %0d expected %0d", got, cyc - e.cyc, LAT12);
                    else passed++;
`ifdef PIPE_APPROX_ADDER_ERR_STATS_EN
                    if (e.diff) exp_err++;
`endif
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (got != n) $display("FAIL modes_timeout got %0d results expected %0d", got, n); else passed++;
        @(negedge clk);
        checks++; if (bus.err_count !== 16'(exp_err)) $display("FAIL modes_err_count got %0d expected %0d", bus.err_count, exp_err); else passed++;
    endtask

    task automatic test_backpressure();
        int   sent = 0, got = 0, guard = 0, n;
        exp_t e;
        load_ops();
        add_op(12'h3C7, 12'h111, 1'b0, 1'b1);
        add_op(12'h800, 12'h7FF, 1'b1, 1'b0);
        add_op(12'hA5A, 12'h5A5, 1'b0, 1'b1);
        add_op(12'h00F, 12'h00F, 1'b1, 1'b0);
        add_op(12'hFF8, 12'h008, 1'b0, 1'b1);
        n = op_a.size();
        while (got < n && guard < 200) begin
            @(posedge clk); #1; guard++;
            bus.out_ready = (guard > 6);
            if (sent < n) drive_op(sent); else bus.in_valid = 1'b0;
            @(negedge clk);
            if (guard == 6) begin
                checks++; if (sent != LAT12) $display("FAIL bp_accepted got %0d expected %0d", sent, LAT12); else passed++;
                checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b expected 0", bus.in_ready); else passed++;
            end
            if (!bus.out_ready && bus.out_valid && sb.size() > 0) begin
                checks++;
                if ({bus.cout, bus.s} !== {sb[0].cout, sb[0].s[11:0]})
                    $display("FAIL bp_hold cycle%0d got %h expected %h", guard, {bus.cout, bus.s}, {sb[0].cout, sb[0].s[11:0]});
                else passed++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model12(bus.a, bus.b, bus.cin, bus.approx_en, cyc)); sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) $display("FAIL bp_spurious_output got valid expected none");
                else begin
                    e = sb.pop_front();
                    if ({bus.cout, bus.s} !== {e.cout, e.s[11:0]})
                        $display("FAIL bp_sum op%0d got %h expected %h", got, {bus.cout, bus.s}, {e.cout, e.s[11:0]});
                    else passed++;
`ifdef PIPE_APPROX_ADDER_ERR_STATS_EN
                    if (e.diff) exp_err++;
`endif
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got != n) $display("FAIL bp_timeout got %0d results expected %0d", got, n); else passed++;
        @(negedge clk);
        checks++; if (bus.err_count !== 16'(exp_err)) $display("FAIL bp_err_count got %0d expected %0d", bus.err_count, exp_err); else passed++;
    endtask

    task automatic test_reset_mid();
        int   sent = 0, got = 0, stray = 0, guard = 0;
        exp_t e;
        load_ops();
        add_op(12'h0A5, 12'h013, 1'b0, 1'b1);
        add_op(12'h0F8, 12'h001, 1'b0, 1'b1);
        add_op(12'h0F8, 12'h001, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive_op(i);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        checks++; if (sent != 2) $display("FAIL rst_mid_accepted got %0d expected 2", sent); else passed++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b expected 0", bus.out_valid); else passed++;
        checks++; if ({bus.cout, bus.s} !== 13'd0) $display("FAIL rst_mid_sum got %h expected 0", {bus.cout, bus.s}); else passed++;
        checks++; if (bus.err_count !== 16'd0) $display("FAIL rst_mid_err_count got %0d expected 0", bus.err_count); else passed++;
        sb.delete();
        exp_err = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        checks++; if (stray != 0) $display("FAIL rst_mid_stale got %0d results expected 0", stray); else passed++;
        sent = 0;
        while (got < 1 && guard < 50) begin
            @(posedge clk); #1; guard++;
            if (sent < 1) drive_op(2); else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model12(bus.a, bus.b, bus.cin, bus.approx_en, cyc)); sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) $display("FAIL rst_mid_spurious got valid expected none");
                else begin
                    e = sb.pop_front();
                    if ({bus.cout, bus.s} !== {e.cout, e.s[11:0]})
                        $display("FAIL rst_mid_sum_after got %h expected %h", {bus.cout, bus.s}, {e.cout, e.s[11:0]});
                    else passed++;
                    checks++;
                    if (cyc - e.cyc != LAT12) $display("FAIL rst_mid_latency got %0d expected %0d", cyc - e.cyc, LAT12);
                    else passed++;
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 1) $display("FAIL rst_mid_timeout got %0d results expected 1", got); else passed++;
    endtask

    task automatic test_sweep();
        int          sent = 0, got = 0, guard = 0, bad = 0;
        int          n = 1000;
        logic [16:0] r;
        exp_t        e;
        exp_t        q16 [$];
        bus16.out_ready = 1'b1;
        while (got < n && guard < 4000) begin
            @(posedge clk); #1; guard++;
            if (sent < n && $urandom_range(0, 9) < 8) begin
                bus16.in_valid  = 1'b1;
                bus16.a         = 16'($urandom);
                bus16.b         = 16'($urandom);
                bus16.cin       = 1'($urandom);
                bus16.approx_en = 1'($urandom);
            end else bus16.in_valid = 1'b0;
            @(negedge clk);
            if (bus16.in_valid && bus16.in_ready) begin
                r = {1'b0, bus16.a} + {1'b0, bus16.b} + {16'd0, bus16.cin};
                e.s = r[15:0]; e.cout = r[16]; e.diff = 1'b0; e.cyc = cyc;
                q16.push_back(e); sent++;
            end
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                if (q16.size() == 0) $display("FAIL sweep_spurious got valid expected none");
                else begin
                    e = q16.pop_front();
                    if ({bus16.cout, bus16.s} !== {e.cout, e.s}) begin
                        bad++;
                        if (bad < 10) $display("FAIL sweep_sum op%0d got %h expected %h", got, {bus16.cout, bus16.s}, {e.cout, e.s});
                    end else passed++;
                    checks++;
                    if (cyc - e.cyc != LAT16) $display("FAIL sweep_latency op%0d got %0d expected %0d", got, cyc - e.cyc, LAT16);
                    else passed++;
                end
                got++;
            end
        end
        bus16.in_valid = 1'b0;
        checks++; if (got != n) $display("FAIL sweep_timeout got %0d results expected %0d", got, n); else passed++;
        checks++; if (bus16.err_count !== 16'd0) $display("FAIL sweep_err_count got %0d expected 0", bus16.err_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_approx_modes();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
